unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores) of the five-stage core. Data requests take fixed priority, with an optional fetch starvation guard. The block latches the winning request, holds it on the memory port until the memory acknowledges, and returns the response to the owner. A fetch flush, driven by a taken branch or jump in execute, discards an in-flight instruction read.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits. Used only with the guard compiled in; legal range 1..15.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch address, word aligned
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  instruction data valid, one-cycle pulse
- if_rdata  out  32  instruction word; valid only with if_rvalid
- if_flush  in  1  discard any fetch pending or in flight
- dm_req  in  1  data request; held with all dm_* fields until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_wstrb  in  4  byte enables for stores
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  load data valid or store done, one-cycle pulse
- dm_rdata  out  32  raw load word; the memory stage does sign/zero extension
- mem_req  out  1  transaction valid on the memory port (registered)
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/32/32/4  latched transaction fields
- mem_ready  in  1  memory completes the current transaction this cycle
- mem_rdata  in  32  read data; valid when mem_ready = 1

## Operation
- States:
  - IDLE: no transaction.
  - BUSY_IF: fetch owns the port.
  - BUSY_DM: data owns the port.
- An arbitration point is any cycle in IDLE, or any BUSY cycle with mem_ready = 1.
- At an arbitration point the winner is chosen as follows:
  - dm_req wins over if_req.
  - if_req counts only when if_flush = 0.
  - If neither request is valid, the next state is IDLE.
- The winner's gnt is asserted in that cycle. Its fields are latched into the mem_* registers and the next state is BUSY_IF or BUSY_DM.
- mem_req = 1 exactly when the state is BUSY_*. The mem_* fields stay stable until mem_ready.
- On mem_ready:
  - In BUSY_DM, dm_rvalid = 1 and dm_rdata = mem_rdata.
  - In BUSY_IF, if_rvalid = 1 and if_rdata = mem_rdata, unless drop is set.
- drop flag:
  - Set by if_flush in a BUSY_IF cycle.
  - Cleared at the end of that transaction.
  - When set, the response is consumed silently and if_rvalid stays 0.
- Fetches have mem_we = 0 and mem_wstrb = 4'b0000.

## Timing
- Reset values: state IDLE, mem_req 0, mem_* fields 0, both rvalid 0, both rdata 0, drop 0, starvation counter 0.
- Requester-visible latency:
  - Request accepted in cycle N from IDLE.
  - mem_req = 1 in cycle N+1.
  - rvalid in the cycle mem_ready arrives, at N+1 at the earliest.
- Back-to-back transactions: a request granted in the mem_ready cycle keeps mem_req = 1 with no gap. Sustained throughput is one transaction per memory latency.
- Both requests in the same cycle: dm_gnt = 1, if_gnt = 0, and if_req stays pending.
- if_flush in the same cycle as an arbitration point with only if_req valid: no grant, next state IDLE.
- if_flush in the mem_ready cycle of BUSY_IF: if_rvalid is suppressed in that same cycle.
- Reset asserted mid-transaction: the port is abandoned immediately. The memory must tolerate mem_req dropping.
- No timeout. mem_ready never arriving stalls both stages.

## Configuration
- FETCH_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each dm_gnt issued while if_req = 1 and if_flush = 0.
  - The counter clears on if_gnt and whenever if_req = 0.
  - When the counter reaches STARVE_LIMIT, the next arbitration point with a valid fetch grants fetch over data.
- Not defined: strict data priority; no counter is instantiated.

## Structure
- Shared package additions:
  - Arb_State_Case enum: IDLE = 2'b00, BUSY_IF = 2'b01, BUSY_DM = 2'b10.
  - Mem_Req_Bundle packed struct: we, addr, wdata, wstrb.
  - Constant STARVE_LIMIT_DEFAULT = 4.
- No sub-module: the FSM, latch, and counter fit in one module.

## Test plan
- Fetch only, memory latency 2: if_req at cycle 0 → if_gnt at 0, mem_req at 1–2, if_rvalid at 2 with data 0x00500093.
- Both requesting at cycle 0, latency 1: dm_gnt at 0, if_gnt at 1 (mem_ready cycle), no idle gap on mem_req.
- if_flush during BUSY_IF, then mem_ready: if_rvalid stays 0; the next dm_req is granted in the mem_ready cycle.
- Store 0xDEADBEEF, wstrb 4'b0011, to 0x100: mem_* fields match for the whole transaction; dm_rvalid pulses once.
- Guard enabled, STARVE_LIMIT = 2, dm_req and if_req held high: grant order DM, DM, IF, DM, DM, IF.
- rst_n low during BUSY_DM: mem_req = 0 asynchronously and all outputs at reset values; after release, the first grant follows normal priority.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_pkg
//   Shared types and constants for the unified memory port arbiter.
//   - arb_state_case_e : arbiter ownership state of the memory port
//   - mem_req_bundle_t : one latched memory transaction (we/addr/wdata/wstrb)
//   - STARVE_LIMIT_DEFAULT : default data-grant budget while a fetch waits
//   - fetch_bundle()   : builds the transaction for an instruction read
// ---------------------------------------------------------------------------
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } arb_state_case_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_bundle_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int STARVE_CNT_W         = 4;
  localparam int STARVE_CNT_MAX       = (1 << STARVE_CNT_W) - 1;

  // Instruction reads never write: no write enable, no byte strobes.
  function automatic mem_req_bundle_t fetch_bundle(input logic [31:0] addr);
    mem_req_bundle_t b;
    b.we    = 1'b0;
    b.addr  = addr;
    b.wdata = 32'h0000_0000;
    b.wstrb = 4'b0000;
    return b;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares the single unified memory port between the fetch stage and the
//   memory stage. Data requests have fixed priority over fetches. The winning
//   request is latched onto the mem_* port and held until mem_ready, and the
//   response is routed back to whichever stage owns the port. A fetch flush
//   discards a pending fetch and silently drops an in-flight instruction read.
//
//   Optional feature (compile-time macro FETCH_STARVE_GUARD_EN):
//     a 4-bit counter limits consecutive data grants while a fetch waits;
//     after STARVE_LIMIT of them the next arbitration with a valid fetch
//     grants the fetch. Without the macro, data priority is strict and no
//     counter exists.
//
//   Parameters:
//     STARVE_LIMIT  data grants allowed while a fetch waits (1..15)
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     if_req/if_addr/if_flush        fetch request, address, flush
//     if_gnt/if_rvalid/if_rdata      fetch accept, response pulse, data
//     dm_req/dm_we/dm_addr/
//       dm_wdata/dm_wstrb            data request and its fields
//     dm_gnt/dm_rvalid/dm_rdata      data accept, response pulse, raw word
//     mem_req/mem_we/mem_addr/
//       mem_wdata/mem_wstrb          registered memory transaction
//     mem_ready/mem_rdata            memory completion and read data
// ---------------------------------------------------------------------------
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        if_flush,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > STARVE_CNT_MAX) begin : g_limit_range
    $error("unified_mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  arb_state_case_e state_q, state_d;
  mem_req_bundle_t bundle_q, bundle_d;
  logic            drop_q, drop_d;

  logic arb_point;
  logic if_valid;
  logic fetch_first;
  logic grant_dm;
  logic grant_if;
  logic resp_if;
  logic resp_dm;

  // The port is re-arbitrated when idle or when the current transaction
  // completes; gating with rst_n keeps grants quiet while reset is held.
  assign arb_point = rst_n && ((state_q == IDLE) || mem_ready);

  // A flushed fetch is stale and must not compete for the port.
  assign if_valid  = if_req && !if_flush;

  assign grant_dm  = arb_point && dm_req && !fetch_first;
  assign grant_if  = arb_point && if_valid && !grant_dm;
  assign dm_gnt    = grant_dm;
  assign if_gnt    = grant_if;

`ifdef FETCH_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign fetch_first = if_valid && (starve_cnt_q >= STARVE_CNT_W'(STARVE_LIMIT));

  // Counts data grants that overtook a live fetch; saturates rather than
  // wrapping so a very long data burst cannot re-arm the budget.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if || !if_req) begin
      starve_cnt_d = '0;
    end else if (grant_dm && if_valid &&
                 (starve_cnt_q != STARVE_CNT_W'(STARVE_CNT_MAX))) begin
      starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Next state, transaction latch and drop flag.
  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    drop_d   = drop_q;

    if (grant_dm) begin
      state_d        = BUSY_DM;
      bundle_d.we    = dm_we;
      bundle_d.addr  = dm_addr;
      bundle_d.wdata = dm_wdata;
      bundle_d.wstrb = dm_wstrb;
    end else if (grant_if) begin
      state_d  = BUSY_IF;
      bundle_d = fetch_bundle(if_addr);
    end else if (arb_point) begin
      state_d = IDLE;
    end

    // drop survives until its own transaction ends; a flush in the
    // completion cycle is handled directly on if_rvalid below.
    if ((state_q == BUSY_IF) && !mem_ready) begin
      drop_d = drop_q | if_flush;
    end else begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bundle_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      drop_q   <= drop_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = bundle_q.we;
  assign mem_addr  = bundle_q.addr;
  assign mem_wdata = bundle_q.wdata;
  assign mem_wstrb = bundle_q.wstrb;

  // Responses are routed combinationally in the mem_ready cycle.
  assign resp_if   = (state_q == BUSY_IF) && mem_ready;
  assign resp_dm   = (state_q == BUSY_DM) && mem_ready;

  assign if_rvalid = resp_if && !drop_q && !if_flush;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0000_0000;
  assign dm_rvalid = resp_dm;
  assign dm_rdata  = resp_dm ? mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_wstrb;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_flush(if_flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural reference: who owns the port, what transaction it carries,
  // whether the fetch response is to be discarded, and how many data grants
  // have overtaken a waiting fetch.
  int          owner;            // 0 = nobody, 1 = fetch, 2 = data
  logic        t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wstrb;
  bit          drop;
  int          starve;
  bit          e_if_gnt, e_dm_gnt;
  string       dut_log;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic reset_model();
    owner = 0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_wstrb = '0;
    drop = 1'b0; starve = 0; e_if_gnt = 1'b0; e_dm_gnt = 1'b0;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  // Evaluate the current cycle against the model (inputs already settled).
  task automatic check_cycle();
    bit decide, fetch_ok, fetch_first, e_if_rv, e_dm_rv;
    decide   = (owner == 0) || mem_ready;
    fetch_ok = if_req && !if_flush;
`ifdef FETCH_STARVE_GUARD_EN
    fetch_first = fetch_ok && (starve >= LIMIT);
`else
    fetch_first = 1'b0;
`endif
    e_dm_gnt = decide && dm_req && !fetch_first;
    e_if_gnt = decide && fetch_ok && !e_dm_gnt;
    e_if_rv  = (owner == 1) && mem_ready && !drop && !if_flush;
    e_dm_rv  = (owner == 2) && mem_ready;

    chk1("mem_req", mem_req, owner != 0);
    chk1("dm_gnt", dm_gnt, e_dm_gnt);
    chk1("if_gnt", if_gnt, e_if_gnt);
    chk1("if_rvalid", if_rvalid, e_if_rv);
    chk1("dm_rvalid", dm_rvalid, e_dm_rv);
    if (e_if_rv) chk("if_rdata", if_rdata, mem_rdata);
    if (e_dm_rv) chk("dm_rdata", dm_rdata, mem_rdata);
    if (owner != 0) begin
      chk1("mem_we", mem_we, t_we);
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(t_wstrb));
      if (owner == 2) chk("mem_wdata", mem_wdata, t_wdata);
    end
    if (dm_gnt) dut_log = {dut_log, "D"};
    else if (if_gnt) dut_log = {dut_log, "I"};
  endtask

  // Advance the model across the clock edge using the sampled inputs.
  task automatic update_model();
    bit decide;
    decide = (owner == 0) || mem_ready;
    if (e_if_gnt || !if_req) starve = 0;
    else if (e_dm_gnt && !if_flush && starve < 15) starve++;
    if (owner == 1 && !mem_ready) drop = drop | if_flush;
    else drop = 1'b0;
    if (e_dm_gnt) begin
      owner = 2; t_we = dm_we; t_addr = dm_addr; t_wdata = dm_wdata; t_wstrb = dm_wstrb;
    end else if (e_if_gnt) begin
      owner = 1; t_we = 1'b0; t_addr = if_addr; t_wstrb = 4'b0000;
    end else if (decide) begin
      owner = 0;
    end
  endtask

  // Called at a falling edge with inputs set: check, clock, back to falling edge.
  task automatic step();
    #1 check_cycle();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  initial begin
    string exp_order;
    idle_inputs();
    reset_model();
    dut_log = "";
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_dm_rvalid", dm_rvalid, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch only, memory latency 2.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    #1 chk1("t1_if_gnt", if_gnt, 1'b1);
    step();
    if_req = 1'b0;
    #1 chk1("t1_mem_req_c1", mem_req, 1'b1);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    #1 chk1("t1_if_rvalid", if_rvalid, 1'b1);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    step();
    mem_ready = 1'b0;
    #1 chk1("t1_mem_req_done", mem_req, 1'b0);
    step();

    // Both requesting, latency 1.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    #1 chk1("t2_dm_gnt", dm_gnt, 1'b1);
    chk1("t2_if_gnt_blocked", if_gnt, 1'b0);
    step();
    dm_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    #1 chk1("t2_if_gnt_at_ready", if_gnt, 1'b1);
    chk1("t2_dm_rvalid", dm_rvalid, 1'b1);
    step();
    if_req = 1'b0; mem_rdata = 32'h3333_4444;
    #1 chk1("t2_no_gap", mem_req, 1'b1);
    chk("t2_if_addr", mem_addr, 32'h0000_0044);
    step();
    mem_ready = 1'b0;
    step();

    // Flush while a fetch is in flight, then a data request at mem_ready.
    if_req = 1'b1; if_addr = 32'h0000_0048;
    step();
    if_req = 1'b0; if_flush = 1'b1;
    step();
    if_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD0_0001;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
    #1 chk1("t3_if_rvalid_dropped", if_rvalid, 1'b0);
    chk1("t3_dm_gnt_at_ready", dm_gnt, 1'b1);
    step();
    dm_req = 1'b0; mem_rdata = 32'h0000_0abc;
    #1 chk1("t3_dm_rvalid", dm_rvalid, 1'b1);
    step();
    mem_ready = 1'b0;
    step();

    // Flush in the completion cycle, then a flushed fetch at an idle point.
    if_req = 1'b1; if_addr = 32'h0000_004C;
    step();
    if_req = 1'b0; mem_ready = 1'b1; if_flush = 1'b1; mem_rdata = 32'hBAD0_0002;
    #1 chk1("t3b_if_rvalid_same_cycle", if_rvalid, 1'b0);
    step();
    mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0050;
    #1 chk1("t3b_flushed_no_gnt", if_gnt, 1'b0);
    step();
    if_req = 1'b0; if_flush = 1'b0;
    #1 chk1("t3b_stays_idle", mem_req, 1'b0);
    step();

    // Store held for a latency of 3.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100;
    dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011;
    step();
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1;
      chk1("t4_mem_we", mem_we, 1'b1);
      chk("t4_mem_addr", mem_addr, 32'h0000_0100);
      chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t4_mem_wstrb", 32'(mem_wstrb), 32'h3);
      chk1("t4_dm_rvalid", dm_rvalid, i == 2);
      step();
    end
    mem_ready = 1'b0;
    #1 chk1("t4_dm_rvalid_once", dm_rvalid, 1'b0);
    step();

    // Both requests held high, latency 1: grant order.
    dut_log = "";
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0500;
    if_req = 1'b1; if_addr = 32'h0000_0060;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (owner != 0);
      mem_rdata = 32'h0000_1000 + 32'(i);
      step();
    end
`ifdef FETCH_STARVE_GUARD_EN
    exp_order = "DDIDDI";
`else
    exp_order = "DDDDDD";
`endif
    n_chk++;
    assert (dut_log == exp_order) n_pass++;
    else $error("FAIL t5_grant_order observed=%s expected=%s", dut_log, exp_order);
    dm_req = 1'b0; if_req = 1'b0; mem_ready = (owner != 0);
    step();
    mem_ready = 1'b0;
    step();

    // Reset asserted in the middle of a data transaction.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0400;
    dm_wdata = 32'h1234_5678; dm_wstrb = 4'b1111;
    step();
    dm_req = 1'b0;
    #1 chk1("t6_busy_before_reset", mem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("t6_mem_req_async", mem_req, 1'b0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_mem_wdata", mem_wdata, 32'h0);
    chk1("t6_mem_we", mem_we, 1'b0);
    chk1("t6_dm_rvalid", dm_rvalid, 1'b0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0600;
    if_req = 1'b1; if_addr = 32'h0000_0070;
    #1 chk1("t6_post_dm_gnt", dm_gnt, 1'b1);
    chk1("t6_post_if_gnt", if_gnt, 1'b0);
    step();
    dm_req = 1'b0;
    mem_ready = 1'b1;
    step();
    if_req = 1'b0;
    step();
    mem_ready = 1'b0;
    step();

    // Randomised traffic against the reference model.
    idle_inputs();
    for (int c = 0; c < 1500; c++) begin
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = $urandom;
        dm_wdata = $urandom;
        dm_wstrb = dm_we ? 4'($urandom_range(1, 15)) : 4'b0000;
      end
      if (!if_req && $urandom_range(0, 1) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if_flush = ($urandom_range(0, 9) == 0);
      if (if_flush && if_req) if_addr = $urandom & 32'hFFFF_FFFC;
      mem_ready = (owner != 0) && ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      step();
      if (e_dm_gnt) dm_req = 1'b0;
      if (e_if_gnt) if_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
